// File: rtl/run_detector.sv
// Serial run detector: flags runs of RUN_LEN equal bits (ones, zeros or either),
// with overlapping or restarting detection and a saturating hit counter.
module run_detector #(
  parameter int RUN_LEN = 4,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8,
  localparam int CW     = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  input  logic             valid,
  input  logic             clear,
  input  logic [1:0]       mode,
  output logic             z,
  output logic [CW:0]      state,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [CW-1:0] FULL = CW'(RUN_LEN);

  logic          last_bit, last_nxt;
  logic [CW-1:0] run_cnt, cnt_nxt;
  logic          hit;

  function automatic logic pol_ok(input logic b, input logic [1:0] m);
    return m[1] | (b == ~m[0]);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_bit    <= 1'b0;
      run_cnt     <= '0;
      match_count <= '0;
    end else if (clear) begin
      last_bit    <= 1'b0;
      run_cnt     <= '0;
      match_count <= '0;
    end else begin
      last_bit <= last_nxt;
      run_cnt  <= cnt_nxt;
      if (hit && match_count != '1)
        match_count <= match_count + CNT_W'(1);
    end
  end

  // run_cnt == 0 marks "no run yet", so the first sample always starts a run
  always_comb begin
    last_nxt = last_bit;
    cnt_nxt  = run_cnt;
    if (valid) begin
      if (run_cnt == '0 || w != last_bit) begin
        cnt_nxt  = CW'(1);
        last_nxt = w;
      end else if (run_cnt < FULL) begin
        cnt_nxt = run_cnt + CW'(1);
      end else if (OVERLAP == 0) begin
        cnt_nxt = CW'(1);
      end
    end
    hit = valid && (cnt_nxt == FULL) && pol_ok(w, mode);
  end

  always_comb begin
    z     = (run_cnt == FULL) && pol_ok(last_bit, mode);
    state = {last_bit, run_cnt};
  end

endmodule

// File: tb/tb_run_detector.sv
// Bench for run_detector: three instances (overlap, restart, 2-bit counter) against
// a trailing-run-length model, plus hand-computed checks from the test plan.
module tb_run_detector;
  localparam int RL = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       w = 1'b0, valid = 1'b0, clear = 1'b0;
  logic [1:0] mode = 2'b00;

  logic       z_a, z_b, z_c;
  logic [3:0] st_a, st_b, st_c;
  logic [7:0] mc_a, mc_b;
  logic [1:0] mc_c;

  int tests = 0;
  int fails = 0;

  // Model: length of the trailing run of equal valid samples since reset/clear,
  // and event counts for sliding vs restarting detection.
  int runlen = 0;
  bit lastb  = 1'b0;
  int ev_ov  = 0;
  int ev_no  = 0;

  run_detector #(.RUN_LEN(RL), .OVERLAP(1), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .w(w), .valid(valid), .clear(clear), .mode(mode),
    .z(z_a), .state(st_a), .match_count(mc_a));
  run_detector #(.RUN_LEN(RL), .OVERLAP(0), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .w(w), .valid(valid), .clear(clear), .mode(mode),
    .z(z_b), .state(st_b), .match_count(mc_b));
  run_detector #(.RUN_LEN(RL), .OVERLAP(1), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .w(w), .valid(valid), .clear(clear), .mode(mode),
    .z(z_c), .state(st_c), .match_count(mc_c));

  always #5 clk = ~clk;

  function automatic bit pol(input bit b, input logic [1:0] m);
    return m[1] || (b == !m[0]);
  endfunction

  function automatic int new_len(input int l, input bit lb, input bit x);
    return (l == 0 || x != lb) ? 1 : l + 1;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset || clear) begin
      runlen <= 0; lastb <= 1'b0; ev_ov <= 0; ev_no <= 0;
    end else if (valid) begin
      runlen <= new_len(runlen, lastb, w);
      lastb  <= w;
      ev_ov  <= ev_ov + int'(new_len(runlen, lastb, w) >= RL && pol(w, mode));
      ev_no  <= ev_no + int'(new_len(runlen, lastb, w) % RL == 0 && pol(w, mode));
    end
  end

  // Per-cycle compare of every instance against the model
  always @(negedge clk) begin
    int cov, cno;
    cov = imin(runlen, RL);
    cno = (runlen == 0) ? 0 : ((runlen - 1) % RL) + 1;
    check("a.z", 32'(z_a), 32'(cov == RL && pol(lastb, mode)));
    check("a.state", 32'(st_a), 32'(int'(lastb) * 8 + cov));
    check("a.count", 32'(mc_a), 32'(imin(ev_ov, 255)));
    check("b.z", 32'(z_b), 32'(cno == RL && pol(lastb, mode)));
    check("b.state", 32'(st_b), 32'(int'(lastb) * 8 + cno));
    check("b.count", 32'(mc_b), 32'(imin(ev_no, 255)));
    check("c.z", 32'(z_c), 32'(cov == RL && pol(lastb, mode)));
    check("c.state", 32'(st_c), 32'(int'(lastb) * 8 + cov));
    check("c.count", 32'(mc_c), 32'(imin(ev_ov, 3)));
  end

  task automatic step(input logic x, input logic v, input logic c);
    w = x; valid = v; clear = c;
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("rst.z", 32'({z_a, z_b, z_c}), 32'd0);
    check("rst.state", 32'({st_a, st_b, st_c}), 32'd0);
    check("rst.count", 32'({mc_a, mc_b, mc_c}), 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin : stim
    int bseq[8] = '{1, 2, 3, 4, 1, 2, 3, 4};
    bit b;
    repeat (2) @(posedge clk);
    #2;
    check("reset.z", 32'(z_a), 32'd0);
    check("reset.state", 32'(st_a), 32'd0);
    check("reset.count", 32'(mc_a), 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;

    // four ones
    repeat (4) step(1'b1, 1'b1, 1'b0);
    check("t1.z", 32'(z_a), 32'd1);
    check("t1.state", 32'(st_a), 32'b1100);
    check("t1.count", 32'(mc_a), 32'd1);

    // six ones then a zero
    step(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b1, 1'b0);
      check("t2.z", 32'(z_a), 32'(k >= 4));
    end
    step(1'b0, 1'b1, 1'b0);
    check("t2.zlow", 32'(z_a), 32'd0);
    check("t2.count", 32'(mc_a), 32'd3);
    check("t2.state", 32'(st_a), 32'b0001);

    // restart detection over 8 ones, then saturation out to 10
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 1'b0);
      check("t3.cnt", 32'(st_b[2:0]), 32'(bseq[k]));
      check("t3.z", 32'(z_b), 32'(k == 3 || k == 7));
    end
    check("t3.count", 32'(mc_b), 32'd2);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    check("sat.count_c", 32'(mc_c), 32'd3);
    check("sat.count_a", 32'(mc_a), 32'd7);

    // zeros under mode 00, then mode 10, then combinational mode drop
    step(1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    check("t4.z0", 32'(z_a), 32'd0);
    check("t4.count0", 32'(mc_a), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    mode = 2'b10;
    repeat (4) step(1'b0, 1'b1, 1'b0);
    check("t4.z1", 32'(z_a), 32'd1);
    check("t4.count1", 32'(mc_a), 32'd1);
    valid = 1'b0;
    mode = 2'b00;
    #1;
    check("t4.zdrop", 32'(z_a), 32'd0);
    check("t4.state", 32'(st_a), 32'b0100);
    check("t4.count2", 32'(mc_a), 32'd1);

    // gaps in valid keep the run; clear beats valid
    mode = 2'b10;
    step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    check("t5.z", 32'(z_a), 32'd1);
    check("t5.count", 32'(mc_a), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    check("t5.state", 32'(st_a), 32'd0);
    check("t5.count_clr", 32'(mc_a), 32'd0);

    // async reset mid-run
    repeat (10) step(1'b1, 1'b1, 1'b0);
    check("t6.pre", 32'(mc_c), 32'd3);
    async_reset_pulse();

    // randomized traffic
    b = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(4, 0) == 0) b = ~b;
      if ($urandom_range(99, 0) == 0) mode = 2'($urandom_range(3, 0));
      if ($urandom_range(299, 0) == 0) async_reset_pulse();
      step(b, 1'($urandom_range(3, 0) != 0), 1'($urandom_range(39, 0) == 0));
    end
    valid = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
